trap_ctrl: RTL

//  Trap sequencer for the machine-mode CSR unit. Sequences synchronous exceptions (ecall, illegal instr,

---
 rtl/trap_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: commits exceptions/mret into CSR writes, a pipeline flush and a fetch redirect.
// Optional timer-interrupt entry is compiled in when TRAP_IRQ_EN is defined.
module trap_ctrl #(
    parameter int XLEN    = 64,
    parameter int CAUSE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exc_req,
    input  logic [CAUSE_W-1:0] exc_code,
    input  logic [XLEN-1:0]    exc_pc,
    input  logic               mret_req,
    input  logic [XLEN-1:0]    mtvec_val,
    input  logic [XLEN-1:0]    mepc_val,
    output logic               excep_wen,
    output logic [XLEN-1:0]    mepc_overri,
    output logic [XLEN-1:0]    mcause_overri,
    output logic               flush,
    output logic               stall,
    output logic               redir_valid,
    output logic [XLEN-1:0]    redir_pc,
    input  logic               redir_ready
`ifdef TRAP_IRQ_EN
    ,
    input  logic               irq_timer,
    input  logic               irq_mie
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        REDIR
    } state_t;

`ifdef TRAP_IRQ_EN
    localparam logic [XLEN-1:0] IRQ_CAUSE = (XLEN'(1) << (XLEN - 1)) | XLEN'(7);
`endif

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            mret_flush_q, mret_flush_d;

    // Low address bits are forced to zero on the way out and are never needed.
    logic unused_bits;
    assign unused_bits = ^{pc_q[0], mtvec_val[1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            cause_q      <= '0;
            target_q     <= '0;
            mret_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cause_q      <= cause_d;
            target_q     <= target_d;
            mret_flush_q <= mret_flush_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cause_d      = cause_q;
        target_d     = target_q;
        mret_flush_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (exc_req) begin
                    state_d = SAVE;
                    pc_d    = exc_pc;
                    cause_d = XLEN'(exc_code);
                end else if (mret_req) begin
                    state_d      = REDIR;
                    target_d     = mepc_val;
                    mret_flush_d = 1'b1;
                end
`ifdef TRAP_IRQ_EN
                else if (irq_timer && irq_mie) begin
                    state_d = SAVE;
                    pc_d    = exc_pc;
                    cause_d = IRQ_CAUSE;
                end
`endif
            end
            SAVE: begin
                state_d  = REDIR;
                target_d = {mtvec_val[XLEN-1:2], 2'b00};
            end
            REDIR: begin
                if (redir_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from state so an async reset clears them without waiting for a clock.
    always_comb begin
        excep_wen     = (state_q == SAVE);
        flush         = (state_q == SAVE) || ((state_q == REDIR) && mret_flush_q);
        stall         = (state_q != IDLE);
        redir_valid   = (state_q == REDIR);
        redir_pc      = (state_q == REDIR) ? target_q : '0;
        mepc_overri   = (state_q == SAVE) ? {pc_q[XLEN-1:1], 1'b0} : '0;
        mcause_overri = (state_q == SAVE) ? cause_q : '0;
    end

endmodule
